// File: rtl/fpu_resp_router.sv
// ============================================================================
// fpu_resp_router: in-order master-ID FIFO routing FPU results as one-hot
// registered response valids.                              Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_resp_router #(
  parameter int unsigned NB_MASTERS = 8,
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FLAG_WIDTH = 5,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  input  logic [ID_WIDTH-1:0]      req_id_i,
  output logic                     req_ready_o,
  input  logic                     fpu_valid_i,
  input  logic [DATA_WIDTH-1:0]    fpu_rdata_i,
  input  logic [FLAG_WIDTH-1:0]    fpu_flag_i,
  output logic [NB_MASTERS-1:0]    data_r_valid_o,
  output logic [DATA_WIDTH-1:0]    data_r_rdata_o,
  output logic [FLAG_WIDTH-1:0]    data_r_flag_o,
  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic                     err_o
);

  localparam int unsigned C_PTR_W = $clog2(DEPTH);
  localparam int unsigned C_CNT_W = C_PTR_W + 1;

  logic [ID_WIDTH-1:0]   r_fifo [DEPTH];
  logic [C_PTR_W-1:0]    r_wptr;
  logic [C_PTR_W-1:0]    r_rptr;
  logic [C_CNT_W-1:0]    r_count;
  logic [C_CNT_W-1:0]    w_count_nxt;
  logic                  r_err;
  logic [NB_MASTERS-1:0] r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [FLAG_WIDTH-1:0] r_flag;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic [ID_WIDTH-1:0]   w_pop_id;
  logic [NB_MASTERS-1:0] w_onehot;
  logic                  w_id_ok;
  logic                  w_err_evt;

  assign w_full   = (r_count == C_CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_pop    = fpu_valid_i && !w_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign w_push   = req_valid_i && (!w_full || w_pop);
  assign w_pop_id = r_fifo[r_rptr];

  for (genvar gi = 0; gi < NB_MASTERS; gi++) begin : g_onehot
    assign w_onehot[gi] = (w_pop_id == ID_WIDTH'(gi));
  end

  // No bit matches when the stored ID is outside the master range.
  assign w_id_ok = |w_onehot;

  assign w_err_evt = (fpu_valid_i && w_empty)
                   || (req_valid_i && w_full && !w_pop)
                   || (w_pop && !w_id_ok);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + C_CNT_W'(1);
      2'b01:   w_count_nxt = r_count - C_CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= req_id_i;
        r_wptr         <= r_wptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_rdata <= '0;
      r_flag  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= (w_pop && w_id_ok) ? w_onehot : '0;
      if (w_pop) begin
        r_rdata <= fpu_rdata_i;
        r_flag  <= fpu_flag_i;
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  assign req_ready_o    = !w_full || fpu_valid_i;
  assign outstanding_o  = r_count;
  assign data_r_valid_o = r_valid;
  assign data_r_rdata_o = r_rdata;
  assign data_r_flag_o  = r_flag;
  assign err_o          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fpu_resp_router.sv
// ============================================================================
// tb_fpu_resp_router: directed self-checking bench for fpu_resp_router.
//                                                          Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fpu_resp_router;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic [2:0]  req_id_i;
  logic        req_ready_o;
  logic        fpu_valid_i;
  logic [31:0] fpu_rdata_i;
  logic [4:0]  fpu_flag_i;
  logic [7:0]  data_r_valid_o;
  logic [31:0] data_r_rdata_o;
  logic [4:0]  data_r_flag_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_resp_router #(
    .NB_MASTERS(8), .ID_WIDTH(3), .DATA_WIDTH(32), .FLAG_WIDTH(5), .DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_id_i(req_id_i), .req_ready_o(req_ready_o),
    .fpu_valid_i(fpu_valid_i), .fpu_rdata_i(fpu_rdata_i), .fpu_flag_i(fpu_flag_i),
    .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o),
    .data_r_flag_o(data_r_flag_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid_i = 1'b0;
    req_id_i    = '0;
    fpu_valid_i = 1'b0;
    fpu_rdata_i = '0;
    fpu_flag_i  = '0;
  endtask

  task automatic push(input logic [2:0] id);
    req_valid_i = 1'b1;
    req_id_i    = id;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    req_valid_i = 1'($urandom);
    req_id_i    = 3'($urandom);
    fpu_valid_i = 1'($urandom);
    fpu_rdata_i = $urandom;
    fpu_flag_i  = 5'($urandom);
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_r_valid_o !== 8'h00 || data_r_rdata_o !== 32'h0 || data_r_flag_o !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_resp: valid=%h rdata=%h flag=%h, required 0/0/0",
               data_r_valid_o, data_r_rdata_o, data_r_flag_o);
    end
    n_checks++;
    if (outstanding_o !== 3'd0 || req_ready_o !== 1'b1 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: cnt=%0d ready=%b err=%b, required 0/1/0",
               outstanding_o, req_ready_o, err_o);
    end
    idle_inputs();
    rst_n = 1'b1;
    repeat (10) step();
    n_checks++;
    if (outstanding_o !== 3'd0 || req_ready_o !== 1'b1 || err_o !== 1'b0 || data_r_valid_o !== 8'h00) begin
      n_fail++;
      $display("FAIL idle: cnt=%0d ready=%b err=%b valid=%h, required 0/1/0/00",
               outstanding_o, req_ready_o, err_o, data_r_valid_o);
    end
  endtask

  task automatic test_single();
    push(3'd5);
    n_checks++;
    if (outstanding_o !== 3'd1) begin
      n_fail++;
      $display("FAIL single_cnt: got %0d, required 1", outstanding_o);
    end
    step();
    step();
    fpu_valid_i = 1'b1;
    fpu_rdata_i = 32'h3F80_0000;
    fpu_flag_i  = 5'h01;
    n_checks++;
    if (data_r_valid_o !== 8'h00) begin
      n_fail++;
      $display("FAIL single_latency: valid=%h before edge, required 00", data_r_valid_o);
    end
    step();
    fpu_valid_i = 1'b0;
    fpu_rdata_i = 32'hDEAD_BEEF;
    fpu_flag_i  = 5'h1F;
    n_checks++;
    if (data_r_valid_o !== 8'b0010_0000 || data_r_rdata_o !== 32'h3F80_0000 ||
        data_r_flag_o !== 5'h01 || outstanding_o !== 3'd0) begin
      n_fail++;
      $display("FAIL single_resp: valid=%h rdata=%h flag=%h cnt=%0d, required 20/3f800000/01/0",
               data_r_valid_o, data_r_rdata_o, data_r_flag_o, outstanding_o);
    end
    step();
    n_checks++;
    if (data_r_valid_o !== 8'h00 || data_r_rdata_o !== 32'h3F80_0000 || data_r_flag_o !== 5'h01) begin
      n_fail++;
      $display("FAIL single_pulse: valid=%h rdata=%h flag=%h, required 00/3f800000/01 (held)",
               data_r_valid_o, data_r_rdata_o, data_r_flag_o);
    end
  endtask

  task automatic test_order_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 4; k++) begin
        push(3'(k));
      end
      #1;
      n_checks++;
      if (req_ready_o !== 1'b0 || outstanding_o !== 3'd4) begin
        n_fail++;
        $display("FAIL order_full r%0d: ready=%b cnt=%0d, required 0/4", r, req_ready_o, outstanding_o);
      end
      fpu_valid_i = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        fpu_rdata_i = 32'h1000 * r + k;
        step();
        n_checks++;
        if (data_r_valid_o !== (8'h01 << k) || data_r_rdata_o !== 32'h1000 * r + k) begin
          n_fail++;
          $display("FAIL order_pop r%0d k%0d: valid=%h rdata=%h, required %h/%h",
                   r, k, data_r_valid_o, data_r_rdata_o, 8'h01 << k, 32'h1000 * r + k);
        end
      end
      fpu_valid_i = 1'b0;
      step();
      n_checks++;
      if (data_r_valid_o !== 8'h00 || outstanding_o !== 3'd0 || err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL order_drain r%0d: valid=%h cnt=%0d err=%b, required 00/0/0",
                 r, data_r_valid_o, outstanding_o, err_o);
      end
    end
  endtask

  task automatic test_full_simul();
    logic [7:0] exp_v [4];
    exp_v[0] = 8'h04; exp_v[1] = 8'h08; exp_v[2] = 8'h10; exp_v[3] = 8'h80;
    for (int k = 1; k <= 4; k++) begin
      push(3'(k));
    end
    req_valid_i = 1'b1;
    req_id_i    = 3'd7;
    fpu_valid_i = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_ready: got %b, required 1", req_ready_o);
    end
    step();
    req_valid_i = 1'b0;
    n_checks++;
    if (outstanding_o !== 3'd4 || data_r_valid_o !== 8'h02) begin
      n_fail++;
      $display("FAIL simul_pop: cnt=%0d valid=%h, required 4/02", outstanding_o, data_r_valid_o);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (data_r_valid_o !== exp_v[k]) begin
        n_fail++;
        $display("FAIL simul_order k%0d: valid=%h, required %h", k, data_r_valid_o, exp_v[k]);
      end
    end
    fpu_valid_i = 1'b0;
    step();
    n_checks++;
    if (outstanding_o !== 3'd0 || err_o !== 1'b0 || data_r_valid_o !== 8'h00) begin
      n_fail++;
      $display("FAIL simul_end: cnt=%0d err=%b valid=%h, required 0/0/00",
               outstanding_o, err_o, data_r_valid_o);
    end
  endtask

  task automatic test_errors();
    fpu_valid_i = 1'b1;
    step();
    fpu_valid_i = 1'b0;
    n_checks++;
    if (data_r_valid_o !== 8'h00 || err_o !== 1'b1 || outstanding_o !== 3'd0) begin
      n_fail++;
      $display("FAIL underflow: valid=%h err=%b cnt=%0d, required 00/1/0",
               data_r_valid_o, err_o, outstanding_o);
    end
    repeat (3) step();
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, required 1", err_o);
    end
    for (int k = 0; k < 4; k++) begin
      push(3'(k));
    end
    push(3'd6);
    n_checks++;
    if (outstanding_o !== 3'd4 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: cnt=%0d err=%b, required 4/1", outstanding_o, err_o);
    end
    fpu_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (data_r_valid_o !== (8'h01 << k)) begin
        n_fail++;
        $display("FAIL overflow_drop k%0d: valid=%h, required %h", k, data_r_valid_o, 8'h01 << k);
      end
    end
    fpu_valid_i = 1'b0;
    step();
    n_checks++;
    if (outstanding_o !== 3'd0 || data_r_valid_o !== 8'h00) begin
      n_fail++;
      $display("FAIL overflow_end: cnt=%0d valid=%h, required 0/00", outstanding_o, data_r_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push(3'd6); push(3'd5); push(3'd4); push(3'd3);
    fpu_valid_i = 1'b1;
    fpu_rdata_i = 32'h4000_0000;
    fpu_flag_i  = 5'h04;
    step();
    fpu_valid_i = 1'b0;
    n_checks++;
    if (data_r_valid_o !== 8'h40 || outstanding_o !== 3'd3 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pre: valid=%h cnt=%0d err=%b, required 40/3/0",
               data_r_valid_o, outstanding_o, err_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (data_r_valid_o !== 8'h00 || data_r_rdata_o !== 32'h0 || data_r_flag_o !== 5'h0 ||
        outstanding_o !== 3'd0 || req_ready_o !== 1'b1 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: valid=%h rdata=%h flag=%h cnt=%0d ready=%b err=%b, required 00/0/0/0/1/0",
               data_r_valid_o, data_r_rdata_o, data_r_flag_o, outstanding_o, req_ready_o, err_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    fpu_valid_i = 1'b1;
    step();
    fpu_valid_i = 1'b0;
    n_checks++;
    if (err_o !== 1'b1 || data_r_valid_o !== 8'h00 || outstanding_o !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_after: err=%b valid=%h cnt=%0d, required 1/00/0",
               err_o, data_r_valid_o, outstanding_o);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_order_wrap();
    test_full_simul();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
